// File: rtl/ap_ctrl_multi_monitor.sv
// ap_ctrl_multi_monitor
// Watches NUM_CH ap_ctrl_hs/chain handshakes in parallel. For each channel it
// counts accepted starts and completed transactions. A small timestamp FIFO
// per channel pairs each completion with its start, so latency stays exact
// when transactions overlap. Statistics are read back through a registered
// channel-select port.
//
// Handshake semantics: a start is accepted on a rising clock edge where
// ap_start & ap_ready is high. A completion is consumed on an edge where
// ap_done & ap_continue is high. Neither side is ever back-pressured by this
// block; it only observes.
module ap_ctrl_multi_monitor #(
  parameter  int NUM_CH   = 4,
  parameter  int CNT_W    = 32,
  parameter  int TS_DEPTH = 4,
  localparam int RD_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int OCC_W    = $clog2(TS_DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic [NUM_CH-1:0] ap_start,
  input  logic [NUM_CH-1:0] ap_ready,
  input  logic [NUM_CH-1:0] ap_done,
  input  logic [NUM_CH-1:0] ap_continue,
  input  logic              finish,
  input  logic [RD_W-1:0]   rd_ch,
  output logic [CNT_W-1:0]  rd_start_cnt,
  output logic [CNT_W-1:0]  rd_done_cnt,
  output logic [CNT_W-1:0]  rd_lat_last,
  output logic [CNT_W-1:0]  rd_lat_min,
  output logic [CNT_W-1:0]  rd_lat_max,
  output logic [OCC_W-1:0]  rd_outstanding,
  output logic [NUM_CH-1:0] ts_overflow,
  output logic [NUM_CH-1:0] proto_err,
  output logic              all_idle,
  output logic              frozen
);

  localparam int              PTR_W    = $clog2(TS_DEPTH);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(TS_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Free-running timestamp; latency is a modular difference, so wrap is harmless.
  logic [CNT_W-1:0] ts;

  // Per-channel timestamp FIFO storage and bookkeeping.
  logic [CNT_W-1:0] ts_mem [NUM_CH][TS_DEPTH];
  logic [PTR_W-1:0] wr_ptr [NUM_CH];
  logic [PTR_W-1:0] rd_ptr [NUM_CH];
  logic [OCC_W-1:0] occ    [NUM_CH];

  // Per-channel statistics.
  logic [CNT_W-1:0] start_cnt [NUM_CH];
  logic [CNT_W-1:0] done_cnt  [NUM_CH];
  logic [CNT_W-1:0] lat_last  [NUM_CH];
  logic [CNT_W-1:0] lat_min   [NUM_CH];
  logic [CNT_W-1:0] lat_max   [NUM_CH];

  // Per-channel event decode.
  logic              run;
  logic [NUM_CH-1:0] ev_s;
  logic [NUM_CH-1:0] ev_d;
  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] fifo_full;
  logic [NUM_CH-1:0] do_push;
  logic [NUM_CH-1:0] do_pop;
  logic [NUM_CH-1:0] do_lat;
  logic [NUM_CH-1:0] do_ovf;
  logic [NUM_CH-1:0] do_perr;
  logic [CNT_W-1:0]  lat_val [NUM_CH];
  logic [OCC_W-1:0]  occ_nxt [NUM_CH];
  logic              idle_nxt;

  // Readback mux.
  logic [CNT_W-1:0] sel_start;
  logic [CNT_W-1:0] sel_done;
  logic [CNT_W-1:0] sel_last;
  logic [CNT_W-1:0] sel_min;
  logic [CNT_W-1:0] sel_max;
  logic [OCC_W-1:0] sel_occ;

  // Decode start/done events into FIFO and statistic actions per channel.
  // Events in the cycle finish is first sampled are already ignored, and clear
  // wins over any event in its cycle.
  always_comb begin
    run      = ~frozen & ~finish & ~clear;
    idle_nxt = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      fifo_empty[c] = (occ[c] == '0);
      fifo_full[c]  = (occ[c] == OCC_FULL);
      ev_s[c]       = run & ap_start[c] & ap_ready[c];
      ev_d[c]       = run & ap_done[c] & ap_continue[c];
      // A done pops whenever there is a stored start to pair with.
      do_pop[c]     = ev_d[c] & ~fifo_empty[c];
      // Start with empty FIFO and simultaneous done passes straight through.
      do_push[c]    = ev_s[c] & ~(ev_d[c] & fifo_empty[c])
                    & (~fifo_full[c] | (ev_d[c] & ~fifo_empty[c]));
      do_lat[c]     = ev_d[c] & (~fifo_empty[c] | ev_s[c]);
      do_ovf[c]     = ev_s[c] & fifo_full[c] & ~ev_d[c];
      do_perr[c]    = ev_d[c] & fifo_empty[c] & ~ev_s[c];
      lat_val[c]    = do_pop[c] ? (ts - ts_mem[c][rd_ptr[c]]) : '0;
      occ_nxt[c]    = occ[c] + OCC_W'(do_push[c]) - OCC_W'(do_pop[c]);
      if (occ_nxt[c] != '0) idle_nxt = 1'b0;
    end
  end

  // Store the current timestamp into a channel FIFO on every accepted push.
  always_ff @(posedge clock) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (do_push[c]) ts_mem[c][wr_ptr[c]] <= ts;
    end
  end

  // Timestamp, FIFO pointers, statistics, sticky flags and freeze state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ts          <= '0;
      frozen      <= 1'b0;
      all_idle    <= 1'b1;
      ts_overflow <= '0;
      proto_err   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr[c]    <= '0;
        rd_ptr[c]    <= '0;
        occ[c]       <= '0;
        start_cnt[c] <= '0;
        done_cnt[c]  <= '0;
        lat_last[c]  <= '0;
        lat_min[c]   <= CNT_MAX;
        lat_max[c]   <= '0;
      end
    end else begin
      ts <= ts + CNT_W'(1);
      if (clear) begin
        // Same as reset except the timestamp keeps running.
        frozen      <= 1'b0;
        all_idle    <= 1'b1;
        ts_overflow <= '0;
        proto_err   <= '0;
        for (int c = 0; c < NUM_CH; c++) begin
          wr_ptr[c]    <= '0;
          rd_ptr[c]    <= '0;
          occ[c]       <= '0;
          start_cnt[c] <= '0;
          done_cnt[c]  <= '0;
          lat_last[c]  <= '0;
          lat_min[c]   <= CNT_MAX;
          lat_max[c]   <= '0;
        end
      end else begin
        if (finish) frozen <= 1'b1;
        all_idle <= idle_nxt;
        for (int c = 0; c < NUM_CH; c++) begin
          occ[c] <= occ_nxt[c];
          if (do_push[c]) wr_ptr[c] <= wr_ptr[c] + PTR_W'(1);
          if (do_pop[c])  rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
          if (ev_s[c] && (start_cnt[c] != CNT_MAX)) start_cnt[c] <= start_cnt[c] + CNT_W'(1);
          if (ev_d[c] && (done_cnt[c] != CNT_MAX))  done_cnt[c]  <= done_cnt[c] + CNT_W'(1);
          if (do_lat[c]) begin
            lat_last[c] <= lat_val[c];
            if (lat_val[c] < lat_min[c]) lat_min[c] <= lat_val[c];
            if (lat_val[c] > lat_max[c]) lat_max[c] <= lat_val[c];
          end
          if (do_ovf[c])  ts_overflow[c] <= 1'b1;
          if (do_perr[c]) proto_err[c]   <= 1'b1;
        end
      end
    end
  end

  // Select the statistics of rd_ch; unmapped selects read as a cleared channel.
  always_comb begin
    sel_start = '0;
    sel_done  = '0;
    sel_last  = '0;
    sel_min   = CNT_MAX;
    sel_max   = '0;
    sel_occ   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_ch == RD_W'(c)) begin
        sel_start = start_cnt[c];
        sel_done  = done_cnt[c];
        sel_last  = lat_last[c];
        sel_min   = lat_min[c];
        sel_max   = lat_max[c];
        sel_occ   = occ[c];
      end
    end
  end

  // Register the readback so rd_* follow rd_ch with one cycle of latency.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_start_cnt   <= '0;
      rd_done_cnt    <= '0;
      rd_lat_last    <= '0;
      rd_lat_min     <= CNT_MAX;
      rd_lat_max     <= '0;
      rd_outstanding <= '0;
    end else if (clear) begin
      rd_start_cnt   <= '0;
      rd_done_cnt    <= '0;
      rd_lat_last    <= '0;
      rd_lat_min     <= CNT_MAX;
      rd_lat_max     <= '0;
      rd_outstanding <= '0;
    end else begin
      rd_start_cnt   <= sel_start;
      rd_done_cnt    <= sel_done;
      rd_lat_last    <= sel_last;
      rd_lat_min     <= sel_min;
      rd_lat_max     <= sel_max;
      rd_outstanding <= sel_occ;
    end
  end

endmodule

// File: tb/tb_ap_ctrl_multi_monitor.sv
// Testbench for ap_ctrl_multi_monitor: directed scenarios plus a randomized run,
// all checked against a queue-based reference model of the monitor's rules.
module tb_ap_ctrl_multi_monitor;

  localparam int NCH   = 3;
  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam logic [W-1:0] ONES = '1;

  // Clock / reset block.
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic           clear;
  logic [NCH-1:0] ap_start, ap_ready, ap_done, ap_continue;
  logic           finish;
  logic [1:0]     rd_ch;
  logic [W-1:0]   rd_start_cnt, rd_done_cnt, rd_lat_last, rd_lat_min, rd_lat_max;
  logic [2:0]     rd_outstanding;
  logic [NCH-1:0] ts_overflow, proto_err;
  logic           all_idle, frozen;

  ap_ctrl_multi_monitor #(.NUM_CH(NCH), .CNT_W(W), .TS_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .finish(finish), .rd_ch(rd_ch),
    .rd_start_cnt(rd_start_cnt), .rd_done_cnt(rd_done_cnt), .rd_lat_last(rd_lat_last),
    .rd_lat_min(rd_lat_min), .rd_lat_max(rd_lat_max), .rd_outstanding(rd_outstanding),
    .ts_overflow(ts_overflow), .proto_err(proto_err), .all_idle(all_idle), .frozen(frozen)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue of outstanding start timestamps per channel.
  logic [W-1:0]   exp_q [NCH][$];
  logic [W-1:0]   m_start [NCH];
  logic [W-1:0]   m_done  [NCH];
  logic [W-1:0]   m_last  [NCH];
  logic [W-1:0]   m_min   [NCH];
  logic [W-1:0]   m_max   [NCH];
  logic [NCH-1:0] m_ovf, m_perr;
  logic           m_frozen;
  logic [W-1:0]   m_ts;

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      exp_q[c].delete();
      m_start[c] = '0; m_done[c] = '0; m_last[c] = '0; m_min[c] = ONES; m_max[c] = '0;
    end
    m_ovf = '0; m_perr = '0; m_frozen = 1'b0;
  endtask

  task automatic model_reset();
    model_clear();
    m_ts = '0;
  endtask

  function automatic bit m_idle();
    for (int c = 0; c < NCH; c++) if (exp_q[c].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Apply one rising edge's worth of inputs to the model.
  task automatic model_step();
    logic [W-1:0] lat;
    bit s, d, has_lat;
    if (reset !== 1'b1) return;
    if (clear) model_clear();
    else if (!m_frozen && !finish) begin
      for (int c = 0; c < NCH; c++) begin
        s = ap_start[c] & ap_ready[c];
        d = ap_done[c] & ap_continue[c];
        has_lat = 0;
        lat = '0;
        if (s && m_start[c] != ONES) m_start[c]++;
        if (d && m_done[c] != ONES) m_done[c]++;
        if (d && exp_q[c].size() > 0) begin
          lat = m_ts - exp_q[c].pop_front();
          has_lat = 1;
          if (s) exp_q[c].push_back(m_ts);
        end else if (d && s) begin
          has_lat = 1;
        end else if (d) begin
          m_perr[c] = 1'b1;
        end else if (s) begin
          if (exp_q[c].size() < DEPTH) exp_q[c].push_back(m_ts);
          else m_ovf[c] = 1'b1;
        end
        if (has_lat) begin
          m_last[c] = lat;
          if (lat < m_min[c]) m_min[c] = lat;
          if (lat > m_max[c]) m_max[c] = lat;
        end
      end
    end
    if (finish && !clear) m_frozen = 1'b1;
    m_ts = m_ts + 1'b1;
  endtask

  // Driver tasks.
  task automatic drive_idle();
    ap_start = '0; ap_ready = '0; ap_done = '0; ap_continue = '0;
    finish = 1'b0; clear = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic do_reset();
    drive_idle();
    rd_ch = '0;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic pulse(input logic [NCH-1:0] s_mask, input logic [NCH-1:0] d_mask);
    ap_start = s_mask; ap_ready = s_mask; ap_done = d_mask; ap_continue = d_mask;
    cycle();
    drive_idle();
  endtask

  task automatic read_ch(input int c);
    drive_idle();
    rd_ch = 2'(c);
    cycle();
  endtask

  task automatic wait_ts(input logic [W-1:0] target);
    for (int i = 0; i < 300 && m_ts != target; i++) cycle();
  endtask

  task automatic test_reset();
    do_reset();
    read_ch(0);
    n_tests++; if (rd_start_cnt !== 8'd0) begin n_fail++; $display("FAIL reset start_cnt: got %0d want 0", rd_start_cnt); end
    n_tests++; if (rd_done_cnt !== 8'd0) begin n_fail++; $display("FAIL reset done_cnt: got %0d want 0", rd_done_cnt); end
    n_tests++; if (rd_lat_min !== 8'hFF) begin n_fail++; $display("FAIL reset lat_min: got %0h want ff", rd_lat_min); end
    n_tests++; if (rd_lat_max !== 8'd0) begin n_fail++; $display("FAIL reset lat_max: got %0d want 0", rd_lat_max); end
    n_tests++; if (all_idle !== 1'b1) begin n_fail++; $display("FAIL reset all_idle: got %b want 1", all_idle); end
    n_tests++; if (frozen !== 1'b0) begin n_fail++; $display("FAIL reset frozen: got %b want 0", frozen); end
    n_tests++; if ({ts_overflow, proto_err} !== '0) begin n_fail++; $display("FAIL reset flags: got %b want 0", {ts_overflow, proto_err}); end
  endtask

  task automatic test_single();
    do_reset();
    wait_ts(8'd10);
    pulse(3'b001, 3'b000);
    wait_ts(8'd25);
    pulse(3'b000, 3'b001);
    read_ch(0);
    n_tests++; if (rd_start_cnt !== 8'd1) begin n_fail++; $display("FAIL single start_cnt: got %0d want 1", rd_start_cnt); end
    n_tests++; if (rd_done_cnt !== 8'd1) begin n_fail++; $display("FAIL single done_cnt: got %0d want 1", rd_done_cnt); end
    n_tests++; if (rd_lat_last !== 8'd15) begin n_fail++; $display("FAIL single lat_last: got %0d want 15", rd_lat_last); end
    n_tests++; if (rd_lat_min !== 8'd15) begin n_fail++; $display("FAIL single lat_min: got %0d want 15", rd_lat_min); end
    n_tests++; if (rd_lat_max !== 8'd15) begin n_fail++; $display("FAIL single lat_max: got %0d want 15", rd_lat_max); end
    n_tests++; if (rd_outstanding !== 3'd0) begin n_fail++; $display("FAIL single outstanding: got %0d want 0", rd_outstanding); end
    n_tests++; if (all_idle !== 1'b1) begin n_fail++; $display("FAIL single all_idle: got %b want 1", all_idle); end
  endtask

  task automatic test_pipelined();
    do_reset();
    wait_ts(8'd5);
    pulse(3'b010, 3'b000);
    pulse(3'b010, 3'b000);
    pulse(3'b010, 3'b000);
    read_ch(1);
    n_tests++; if (rd_outstanding !== 3'd3) begin n_fail++; $display("FAIL pipe peak_outstanding: got %0d want 3", rd_outstanding); end
    n_tests++; if (all_idle !== 1'b0) begin n_fail++; $display("FAIL pipe all_idle_busy: got %b want 0", all_idle); end
    wait_ts(8'd20); pulse(3'b000, 3'b010);
    wait_ts(8'd22); pulse(3'b000, 3'b010);
    wait_ts(8'd30); pulse(3'b000, 3'b010);
    read_ch(1);
    n_tests++; if (rd_lat_last !== 8'd23) begin n_fail++; $display("FAIL pipe lat_last: got %0d want 23", rd_lat_last); end
    n_tests++; if (rd_lat_min !== 8'd15) begin n_fail++; $display("FAIL pipe lat_min: got %0d want 15", rd_lat_min); end
    n_tests++; if (rd_lat_max !== 8'd23) begin n_fail++; $display("FAIL pipe lat_max: got %0d want 23", rd_lat_max); end
    n_tests++; if (rd_done_cnt !== 8'd3) begin n_fail++; $display("FAIL pipe done_cnt: got %0d want 3", rd_done_cnt); end
    n_tests++; if (rd_outstanding !== 3'd0) begin n_fail++; $display("FAIL pipe outstanding: got %0d want 0", rd_outstanding); end
    // Channel select beyond NUM_CH reads as a cleared channel.
    read_ch(3);
    n_tests++; if (rd_start_cnt !== 8'd0) begin n_fail++; $display("FAIL oor start_cnt: got %0d want 0", rd_start_cnt); end
    n_tests++; if (rd_lat_min !== 8'hFF) begin n_fail++; $display("FAIL oor lat_min: got %0h want ff", rd_lat_min); end
    n_tests++; if (rd_lat_max !== 8'd0) begin n_fail++; $display("FAIL oor lat_max: got %0d want 0", rd_lat_max); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) pulse(3'b100, 3'b000);
    read_ch(2);
    n_tests++; if (ts_overflow !== 3'b100) begin n_fail++; $display("FAIL ovf flag: got %b want 100", ts_overflow); end
    n_tests++; if (rd_start_cnt !== 8'd5) begin n_fail++; $display("FAIL ovf start_cnt: got %0d want 5", rd_start_cnt); end
    n_tests++; if (rd_outstanding !== 3'd4) begin n_fail++; $display("FAIL ovf outstanding: got %0d want 4", rd_outstanding); end
    pulse(3'b100, 3'b100);
    read_ch(2);
    n_tests++; if (ts_overflow !== 3'b100) begin n_fail++; $display("FAIL ovf sd_flag: got %b want 100", ts_overflow); end
    n_tests++; if (rd_outstanding !== 3'd4) begin n_fail++; $display("FAIL ovf sd_outstanding: got %0d want 4", rd_outstanding); end
    n_tests++; if (rd_done_cnt !== 8'd1) begin n_fail++; $display("FAIL ovf sd_done_cnt: got %0d want 1", rd_done_cnt); end
    n_tests++; if (rd_start_cnt !== 8'd6) begin n_fail++; $display("FAIL ovf sd_start_cnt: got %0d want 6", rd_start_cnt); end
  endtask

  task automatic test_proto_err();
    do_reset();
    pulse(3'b000, 3'b001);
    read_ch(0);
    n_tests++; if (proto_err !== 3'b001) begin n_fail++; $display("FAIL perr flag: got %b want 001", proto_err); end
    n_tests++; if (rd_done_cnt !== 8'd1) begin n_fail++; $display("FAIL perr done_cnt: got %0d want 1", rd_done_cnt); end
    n_tests++; if (rd_lat_min !== 8'hFF) begin n_fail++; $display("FAIL perr lat_min: got %0h want ff", rd_lat_min); end
    pulse(3'b001, 3'b001);
    read_ch(0);
    n_tests++; if (rd_lat_last !== 8'd0) begin n_fail++; $display("FAIL passthru lat_last: got %0d want 0", rd_lat_last); end
    n_tests++; if (rd_lat_min !== 8'd0) begin n_fail++; $display("FAIL passthru lat_min: got %0d want 0", rd_lat_min); end
    n_tests++; if (rd_done_cnt !== 8'd2) begin n_fail++; $display("FAIL passthru done_cnt: got %0d want 2", rd_done_cnt); end
    n_tests++; if (rd_start_cnt !== 8'd1) begin n_fail++; $display("FAIL passthru start_cnt: got %0d want 1", rd_start_cnt); end
    n_tests++; if (rd_outstanding !== 3'd0) begin n_fail++; $display("FAIL passthru outstanding: got %0d want 0", rd_outstanding); end
  endtask

  task automatic test_wrap();
    do_reset();
    wait_ts(8'd250);
    pulse(3'b001, 3'b000);
    wait_ts(8'd4);
    pulse(3'b000, 3'b001);
    read_ch(0);
    n_tests++; if (rd_lat_last !== 8'd10) begin n_fail++; $display("FAIL wrap lat_last: got %0d want 10", rd_lat_last); end
    n_tests++; if (rd_lat_max !== 8'd10) begin n_fail++; $display("FAIL wrap lat_max: got %0d want 10", rd_lat_max); end
  endtask

  task automatic test_freeze_clear();
    do_reset();
    pulse(3'b001, 3'b000);
    pulse(3'b001, 3'b000);
    finish = 1'b1;
    cycle();
    drive_idle();
    pulse(3'b011, 3'b000);
    pulse(3'b000, 3'b001);
    read_ch(0);
    n_tests++; if (rd_start_cnt !== 8'd2) begin n_fail++; $display("FAIL freeze start_cnt: got %0d want 2", rd_start_cnt); end
    n_tests++; if (rd_done_cnt !== 8'd0) begin n_fail++; $display("FAIL freeze done_cnt: got %0d want 0", rd_done_cnt); end
    n_tests++; if (rd_outstanding !== 3'd2) begin n_fail++; $display("FAIL freeze outstanding: got %0d want 2", rd_outstanding); end
    n_tests++; if (frozen !== 1'b1) begin n_fail++; $display("FAIL freeze frozen: got %b want 1", frozen); end
    read_ch(1);
    n_tests++; if (rd_start_cnt !== 8'd0) begin n_fail++; $display("FAIL freeze ch1_start_cnt: got %0d want 0", rd_start_cnt); end
    clear = 1'b1;
    cycle();
    drive_idle();
    read_ch(0);
    n_tests++; if (rd_start_cnt !== 8'd0) begin n_fail++; $display("FAIL clear start_cnt: got %0d want 0", rd_start_cnt); end
    n_tests++; if (rd_outstanding !== 3'd0) begin n_fail++; $display("FAIL clear outstanding: got %0d want 0", rd_outstanding); end
    n_tests++; if (frozen !== 1'b0) begin n_fail++; $display("FAIL clear frozen: got %b want 0", frozen); end
    n_tests++; if (all_idle !== 1'b1) begin n_fail++; $display("FAIL clear all_idle: got %b want 1", all_idle); end
    pulse(3'b001, 3'b000);
    read_ch(0);
    n_tests++; if (rd_start_cnt !== 8'd1) begin n_fail++; $display("FAIL clear resume_start_cnt: got %0d want 1", rd_start_cnt); end
  endtask

  task automatic test_async_reset();
    do_reset();
    rd_ch = 2'd0;
    ap_start = 3'b111; ap_ready = 3'b111;
    cycle(); cycle(); cycle();
    #2;
    reset = 1'b0;
    #1;
    n_tests++; if (rd_start_cnt !== 8'd0) begin n_fail++; $display("FAIL areset start_cnt: got %0d want 0", rd_start_cnt); end
    n_tests++; if (rd_outstanding !== 3'd0) begin n_fail++; $display("FAIL areset outstanding: got %0d want 0", rd_outstanding); end
    n_tests++; if (rd_lat_min !== 8'hFF) begin n_fail++; $display("FAIL areset lat_min: got %0h want ff", rd_lat_min); end
    n_tests++; if (all_idle !== 1'b1) begin n_fail++; $display("FAIL areset all_idle: got %b want 1", all_idle); end
    model_reset();
    drive_idle();
    @(negedge clock);
    reset = 1'b1;
    pulse(3'b000, 3'b001);
    read_ch(0);
    n_tests++; if (proto_err !== 3'b001) begin n_fail++; $display("FAIL areset perr: got %b want 001", proto_err); end
    n_tests++; if (rd_done_cnt !== 8'd1) begin n_fail++; $display("FAIL areset done_cnt: got %0d want 1", rd_done_cnt); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1200; i++) begin
      for (int c = 0; c < NCH; c++) begin
        ap_start[c]    = ($urandom_range(0, 1) == 1);
        ap_ready[c]    = ($urandom_range(0, 3) != 0);
        ap_done[c]     = ($urandom_range(0, 2) == 0);
        ap_continue[c] = ($urandom_range(0, 3) != 0);
      end
      clear  = ($urandom_range(0, 149) == 0);
      finish = ($urandom_range(0, 299) == 0);
      cycle();
      n_tests++; if (all_idle !== m_idle()) begin n_fail++; $display("FAIL rand all_idle cyc %0d: got %b want %b", i, all_idle, m_idle()); end
      if (i % 40 == 39) begin
        for (int c = 0; c < NCH; c++) begin
          read_ch(c);
          n_tests++; if (rd_start_cnt !== m_start[c]) begin n_fail++; $display("FAIL rand start_cnt ch%0d: got %0d want %0d", c, rd_start_cnt, m_start[c]); end
          n_tests++; if (rd_done_cnt !== m_done[c]) begin n_fail++; $display("FAIL rand done_cnt ch%0d: got %0d want %0d", c, rd_done_cnt, m_done[c]); end
          n_tests++; if (rd_lat_last !== m_last[c]) begin n_fail++; $display("FAIL rand lat_last ch%0d: got %0d want %0d", c, rd_lat_last, m_last[c]); end
          n_tests++; if (rd_lat_min !== m_min[c]) begin n_fail++; $display("FAIL rand lat_min ch%0d: got %0d want %0d", c, rd_lat_min, m_min[c]); end
          n_tests++; if (rd_lat_max !== m_max[c]) begin n_fail++; $display("FAIL rand lat_max ch%0d: got %0d want %0d", c, rd_lat_max, m_max[c]); end
          n_tests++; if (rd_outstanding !== 3'(exp_q[c].size())) begin n_fail++; $display("FAIL rand outstanding ch%0d: got %0d want %0d", c, rd_outstanding, exp_q[c].size()); end
        end
        n_tests++; if (ts_overflow !== m_ovf) begin n_fail++; $display("FAIL rand ts_overflow: got %b want %b", ts_overflow, m_ovf); end
        n_tests++; if (proto_err !== m_perr) begin n_fail++; $display("FAIL rand proto_err: got %b want %b", proto_err, m_perr); end
        n_tests++; if (frozen !== m_frozen) begin n_fail++; $display("FAIL rand frozen: got %b want %b", frozen, m_frozen); end
      end
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    rd_ch = '0;
    test_reset();
    test_single();
    test_pipelined();
    test_overflow();
    test_proto_err();
    test_wrap();
    test_freeze_clear();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ap_ctrl_multi_monitor.md
Name: ap_ctrl_multi_monitor

Overview:
- Synthesizable, parametrised successor to the single-module ap_ctrl status monitor.
- Watches NUM_CH ap_ctrl_hs/chain handshakes in parallel and counts accepted starts and completed transactions per channel.
- Per channel, a timestamp FIFO tracks overlapping (pipelined) transactions, giving exact per-transaction latency with last/min/max statistics.
- Results are read back through a registered channel-select port; used in co-simulation and on-board for dataflow profiling.

Parameters:
- NUM_CH, 4, number of monitored ap_ctrl channels (1..16).
- CNT_W, 32, width of the timestamp, event counters and latency values.
- TS_DEPTH, 4, per-channel timestamp FIFO depth; power of 2, >=2.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of all statistics and FIFOs; timestamp keeps running.
- ap_start  in  NUM_CH  per-channel ap_start.
- ap_ready  in  NUM_CH  per-channel ap_ready.
- ap_done  in  NUM_CH  per-channel ap_done.
- ap_continue  in  NUM_CH  per-channel ap_continue; tie high for ap_ctrl_hs.
- finish  in  1  end of test; freezes statistics.
- rd_ch  in  max(1,$clog2(NUM_CH))  channel select for readback.
- rd_start_cnt  out  CNT_W  accepted starts of rd_ch.
- rd_done_cnt  out  CNT_W  completed transactions of rd_ch.
- rd_lat_last  out  CNT_W  latency of most recent completion.
- rd_lat_min  out  CNT_W  minimum latency.
- rd_lat_max  out  CNT_W  maximum latency.
- rd_outstanding  out  $clog2(TS_DEPTH)+1  FIFO occupancy of rd_ch.
- ts_overflow  out  NUM_CH  sticky: start arrived with FIFO full.
- proto_err  out  NUM_CH  sticky: done with no matching start.
- all_idle  out  1  every channel FIFO empty.
- frozen  out  1  sticky: finish was sampled high.

Behaviour:
- Reset (async, reset=0):
  - Counters, last/max, FIFOs, sticky flags and frozen go to 0; min goes to all-ones; timestamp goes to 0.
  - Outputs: rd_* = 0 except rd_lat_min = all-ones; all_idle = 1.
- Timestamp: free-running CNT_W counter, +1 every cycle, wraps modulo 2^CNT_W. Latency = done_ts - start_ts modulo 2^CNT_W, so wrap is transparent.
- Events per channel c, sampled each rising edge:
  - S = ap_start[c] & ap_ready[c].
  - D = ap_done[c] & ap_continue[c].
- On S:
  - start_cnt increments, saturating at all-ones.
  - If FIFO not full, push the current timestamp.
  - If FIFO full and no simultaneous pop, drop the push and set ts_overflow[c].
- On D with FIFO non-empty:
  - Pop the oldest timestamp and compute latency L.
  - lat_last = L; lat_min = min(lat_min, L); lat_max = max(lat_max, L).
  - done_cnt increments, saturating.
- On D with FIFO empty and no S: set proto_err[c]; done_cnt increments; latency registers unchanged.
- S and D in the same cycle:
  - FIFO non-empty: pop, then push; occupancy unchanged; full does not count as overflow.
  - FIFO empty: combinational pass-through, L = 0; no push; counters both increment.
- Channels are fully independent; any combination of channels may fire in the same cycle.
- Freeze: once finish is sampled 1, frozen = 1 and all event processing stops; readback stays live. Only clear or reset releases frozen.
- clear (synchronous) acts like reset except for the timestamp counter. clear has priority over events in the same cycle.
- Readback:
  - rd_* registered with one-cycle latency from rd_ch.
  - rd_ch >= NUM_CH returns zeros, except rd_lat_min = all-ones.
- all_idle is registered and reflects post-update occupancy.
- Reset asserted mid-transaction discards outstanding timestamps. A done arriving after reset release with an empty FIFO is a proto_err.

Test Plan:
- Single channel, start at ts=10, done at ts=25 -> start_cnt=1, done_cnt=1, lat_last=min=max=15, outstanding=0, all_idle=1.
- ch1 three pipelined starts at ts=5,6,7, dones at 20,22,30 -> lat 15,16,23; min=15, max=23, last=23; peak outstanding=3.
- TS_DEPTH=4, five starts with no done -> ts_overflow[c]=1, start_cnt=5, outstanding=4; then S and D in the same cycle -> no further overflow change, outstanding stays 4.
- Done with empty FIFO -> proto_err=1, done_cnt=1, lat_min stays all-ones. Simultaneous S&D with empty FIFO -> lat_last=0, min=0.
- CNT_W=8: start at ts=250, done at ts=4 (after wrap) -> latency=10.
- finish pulsed, then further starts -> counters unchanged, frozen=1. Then clear -> all stats reset, frozen=0. Async reset mid-burst -> all outputs at reset values without waiting for a clock edge.
